// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for serial_chunk_adder.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow flag.
interface serial_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    // Requester side: issues operations, observes results
    modport master (
        output start, sub, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    // Adder side: accepts operations, produces results
    modport slave (
        input  start, sub, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// clock, LSB slice first, with the inter-slice carry held in a register.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_chunk_adder_if.slave   bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, shift_reg, sum_reg;
    logic [WIDTH-1:0] a_shift, b_shift, shift_next, b_eff;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg, done_reg;
    logic [CHUNK:0]   slice_sum;
    logic             last_slice, load, step;

    // Subtraction is a + ~b + 1: invert B bitwise when sub is set
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_beff
            assign b_eff[gi] = bus.b[gi] ^ bus.sub;
        end
    endgenerate

    // One slice of the add, with a spare bit for the carry out
    assign slice_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_reg};

    // Operand registers drain right; result fills from the MSB end.
    // With a single slice there is nothing left to shift.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign a_shift    = '0;
            assign b_shift    = '0;
            assign shift_next = slice_sum[CHUNK-1:0];
        end else begin : g_multi
            assign a_shift    = {{CHUNK{1'b0}}, a_reg[WIDTH-1:CHUNK]};
            assign b_shift    = {{CHUNK{1'b0}}, b_reg[WIDTH-1:CHUNK]};
            assign shift_next = {slice_sum[CHUNK-1:0], shift_reg[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign last_slice = (cnt_reg == CW'(N - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept start only in IDLE, leave RUN after last slice
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_slice) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on start, process one slice per RUN cycle,
    // publish sum/cout only on the final slice so they hold while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            shift_reg <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                a_reg     <= bus.a;
                b_reg     <= b_eff;
                carry_reg <= bus.sub | bus.cin;
                cnt_reg   <= '0;
            end else if (step) begin
                a_reg     <= a_shift;
                b_reg     <= b_shift;
                shift_reg <= shift_next;
                carry_reg <= slice_sum[CHUNK];
                cnt_reg   <= cnt_reg + CW'(1);
                if (last_slice) begin
                    sum_reg  <= shift_next;
                    cout_reg <= slice_sum[CHUNK];
                    done_reg <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;
    logic msb_carry_in;

    // Carry into the result MSB, recovered from the top bit of the last slice
    assign msb_carry_in = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ slice_sum[CHUNK-1];

    // Signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (step && last_slice) begin
            ovf_reg <= msb_carry_in ^ slice_sum[CHUNK];
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (CHUNK = 1, 4, 16, WIDTH = 16)
// checked against a scoreboard of reference results.
// Define SERIAL_ADDER_OVF_EN to also check the overflow flag.
module tb_serial_chunk_adder;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_drv = 1'b0;
    logic        sub_drv = 1'b0;
    logic        cin_drv = 1'b0;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;
    logic [2:0]  en = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    exp_t q1[$];
    exp_t q4[$];
    exp_t q16[$];
    exp_t e1, e4, e16;

    always #5 clk = ~clk;

    // Posedge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    serial_chunk_adder_if #(.WIDTH(16)) if_c1();
    serial_chunk_adder_if #(.WIDTH(16)) if_c4();
    serial_chunk_adder_if #(.WIDTH(16)) if_c16();

    assign if_c1.start  = start_drv & en[0];
    assign if_c4.start  = start_drv & en[1];
    assign if_c16.start = start_drv & en[2];
    assign if_c1.a  = a_drv;   assign if_c4.a  = a_drv;   assign if_c16.a  = a_drv;
    assign if_c1.b  = b_drv;   assign if_c4.b  = b_drv;   assign if_c16.b  = b_drv;
    assign if_c1.sub = sub_drv; assign if_c4.sub = sub_drv; assign if_c16.sub = sub_drv;
    assign if_c1.cin = cin_drv; assign if_c4.cin = cin_drv; assign if_c16.cin = cin_drv;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(1))  dut_c1  (.clk(clk), .rst(rst), .bus(if_c1));
    serial_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut_c4  (.clk(clk), .rst(rst), .bus(if_c4));
    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (.clk(clk), .rst(rst), .bus(if_c16));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin, input int sc);
        exp_t        r;
        logic [15:0] eb;
        logic [16:0] full;
        eb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, eb} + {16'b0, sub | cin};
        r.sum       = full[15:0];
        r.cout      = full[16];
        r.ovf       = (a[15] == eb[15]) && (full[15] != a[15]);
        r.start_cyc = sc;
        return r;
    endfunction

    // Called at a negedge: drive one start, record expectations for every
    // enabled instance that is idle (and will therefore accept it)
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin);
        exp_t e;
        a_drv = a; b_drv = b; sub_drv = sub; cin_drv = cin; start_drv = 1'b1;
        e = model(a, b, sub, cin, cyc + 1);
        if (en[0] && !if_c1.busy)  q1.push_back(e);
        if (en[1] && !if_c4.busy)  q4.push_back(e);
        if (en[2] && !if_c16.busy) q16.push_back(e);
        $display("op a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d en=%b",
                 a, b, sub, cin, e.sum, e.cout, en);
        @(negedge clk);
        start_drv = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((if_c1.busy || if_c4.busy || if_c16.busy ||
                q1.size() != 0 || q4.size() != 0 || q16.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", {31'b0, (q1.size() == 0 && q4.size() == 0 && q16.size() == 0)}, 1);
    endtask

    // Scoreboard monitors, one per instance
    always @(negedge clk) begin
        if (!rst && if_c1.done) begin
            if (q1.size() == 0) check_eq("c1_spurious_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                check_eq("c1_sum", {16'b0, if_c1.sum}, {16'b0, e1.sum});
                check_eq("c1_cout", {31'b0, if_c1.cout}, {31'b0, e1.cout});
                check_eq("c1_latency", cyc - e1.start_cyc, 16);
`ifdef SERIAL_ADDER_OVF_EN
                check_eq("c1_ovf", {31'b0, if_c1.ovf}, {31'b0, e1.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if_c4.done) begin
            if (q4.size() == 0) check_eq("c4_spurious_done", 1, 0);
            else begin
                e4 = q4.pop_front();
                check_eq("c4_sum", {16'b0, if_c4.sum}, {16'b0, e4.sum});
                check_eq("c4_cout", {31'b0, if_c4.cout}, {31'b0, e4.cout});
                check_eq("c4_latency", cyc - e4.start_cyc, 4);
`ifdef SERIAL_ADDER_OVF_EN
                check_eq("c4_ovf", {31'b0, if_c4.ovf}, {31'b0, e4.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if_c16.done) begin
            if (q16.size() == 0) check_eq("c16_spurious_done", 1, 0);
            else begin
                e16 = q16.pop_front();
                check_eq("c16_sum", {16'b0, if_c16.sum}, {16'b0, e16.sum});
                check_eq("c16_cout", {31'b0, if_c16.cout}, {31'b0, e16.cout});
                check_eq("c16_latency", cyc - e16.start_cyc, 1);
`ifdef SERIAL_ADDER_OVF_EN
                check_eq("c16_ovf", {31'b0, if_c16.ovf}, {31'b0, e16.ovf});
`endif
            end
        end
    end

    initial begin
        int n;
        // Reset state on all instances
        repeat (2) @(negedge clk);
        check_eq("rst_c1_busy", {31'b0, if_c1.busy}, 0);
        check_eq("rst_c4_busy", {31'b0, if_c4.busy}, 0);
        check_eq("rst_c16_busy", {31'b0, if_c16.busy}, 0);
        check_eq("rst_c1_done", {31'b0, if_c1.done}, 0);
        check_eq("rst_c4_done", {31'b0, if_c4.done}, 0);
        check_eq("rst_c16_done", {31'b0, if_c16.done}, 0);
        check_eq("rst_c4_sum", {16'b0, if_c4.sum}, 0);
        check_eq("rst_c4_cout", {31'b0, if_c4.cout}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Add wrap on CHUNK=4: busy for 4 cycles, sum held at old value
        en = 3'b010;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("wrap_busy", {31'b0, if_c4.busy}, 1);
            check_eq("wrap_sum_held", {16'b0, if_c4.sum}, 0);
            check_eq("wrap_no_done", {31'b0, if_c4.done}, 0);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        check_eq("wrap_done", {31'b0, if_c4.done}, 1);
        check_eq("wrap_busy_low", {31'b0, if_c4.busy}, 0);
        wait_idle(20);

        // Subtract with and without borrow (cin ignored)
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_idle(20);
        issue(16'h0007, 16'h0005, 1'b1, 1'b0);
        wait_idle(20);

        // Signed overflow cases
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_idle(20);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_idle(20);

        // Start while busy is ignored; start in done cycle is accepted
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        issue(16'hFFFF, 16'h1111, 1'b0, 1'b0);
        n = 0;
        while (!if_c4.done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_done_seen", {31'b0, if_c4.done}, 1);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_idle(20);

        // Reset mid-operation on CHUNK=1 and CHUNK=4
        en = 3'b011;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_idle(40);
        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_c4_busy", {31'b0, if_c4.busy}, 0);
        check_eq("midrst_c4_done", {31'b0, if_c4.done}, 0);
        check_eq("midrst_c4_sum", {16'b0, if_c4.sum}, 0);
        check_eq("midrst_c4_cout", {31'b0, if_c4.cout}, 0);
        check_eq("midrst_c1_busy", {31'b0, if_c1.busy}, 0);
        check_eq("midrst_c1_sum", {16'b0, if_c1.sum}, 0);
        check_eq("midrst_c1_cout", {31'b0, if_c1.cout}, 0);
        q1.delete();
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(16'h00F0, 16'h0F0F, 1'b0, 1'b0);
        wait_idle(40);

        // Random sweep across all three chunk sizes
        en = 3'b111;
        for (int i = 0; i < 1000; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_idle(40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Parametrised, multi-cycle successor to the team's single-bit full adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock and carries between slices in a register. A start/busy/done handshake lets it sit beside the board-level datapath, for example driving 7-seg or LED result displays. It trades latency for a short carry chain.

Parameters:
WIDTH, 16, operand and result width in bits; must be a positive multiple of CHUNK.
CHUNK, 4, bits added per clock; 1 gives a pure bit-serial adder.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
sub  input  1  0 = add, 1 = subtract (a - b); latched with start.
a  input  WIDTH  operand A; latched with start.
b  input  WIDTH  operand B; latched with start.
cin  input  1  carry-in for add; ignored when sub=1; latched with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  result; held stable between completions.
cout  output  1  final carry-out; in subtract mode 1 = no borrow (a >= b unsigned).

Behaviour:
- N = WIDTH/CHUNK slices. FSM states: IDLE and RUN.
- Reset (async, any state, mid-operation included):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal operand, shift and carry registers are cleared.
  - Any partial result is discarded; no done is issued for the aborted operation.
- IDLE, start=1 at edge k:
  - Latch a, b and sub.
  - Latch effective carry-in = sub ? 1 : cin; effective B = sub ? ~b : b.
  - Clear the slice counter. Go to RUN; busy=1 from edge k.
- RUN, edges k+1 .. k+N, one slice per edge, LSB slice first:
  - slice_sum = A_slice + B_slice + carry, computed as a (CHUNK+1)-bit add.
  - The low CHUNK bits shift into the MSB end of the internal result shift register; bit CHUNK becomes the next carry.
  - Operand registers shift right by CHUNK.
- At edge k+N (last slice):
  - sum <= completed result; cout <= final carry.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done is high N edges after the edge that sampled start (4 for the defaults); throughput is one operation per N cycles.
- start while busy=1 is ignored and not queued. Input changes while busy have no effect.
- start=1 in the done cycle is accepted (state is IDLE), giving back-to-back operations.
- sum and cout keep the previous result while busy; they change only at the completion edge.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- CHUNK=WIDTH is legal: N=1, and done follows start by one edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB of the final slice, using effective B.
  - Registered, reset to 0, updated on the same edge as sum, held until the next completion.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Add wrap: WIDTH=16, CHUNK=4, a=0xFFFF, b=0x0001, cin=0, sub=0, start at edge k -> busy high edges k..k+3; done pulse after edge k+4; sum=0x0000, cout=1 (ovf=0 if enabled).
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Signed overflow (SERIAL_ADDER_OVF_EN defined): a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Start while busy: start a=0x1234, b=0x1111; pulse start with a=0xFFFF at edge k+2 -> single done, sum=0x2345; then start in the done cycle with a=b=0x0001 -> done 4 edges later, sum=0x0002.
- Reset mid-op: assert rst at edge k+2 of a run -> busy=0, done=0, sum=0, cout=0 immediately; no done follows; the next start completes normally.
- Parameter sweep: CHUNK=1, 4, 16 with WIDTH=16; 1000 random a, b, sub, cin -> sum/cout match the reference model; done latency = 16, 4 and 1 edges respectively.
